// File: rtl/sorter_pkg.sv
// ============================================================================
// Module : sorter_pkg
// Brief  : Shared FSM state type and element pack/unpack helpers for sorter_oets.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sorter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Helpers work on a wide carrier vector so they stay independent of N and W.
  localparam int MAX_BITS = 1024;
  localparam int MAX_W    = 64;

  function automatic logic [MAX_W-1:0] unpack_elem(
    input logic [MAX_BITS-1:0] vec,
    input int                  idx,
    input int                  w
  );
    logic [MAX_BITS-1:0] shifted;
    logic [MAX_W-1:0]    mask;
    shifted = vec >> (idx * w);
    mask    = ~({MAX_W{1'b1}} << w);
    return shifted[MAX_W-1:0] & mask;
  endfunction

  function automatic logic [MAX_BITS-1:0] pack_elem(
    input logic [MAX_BITS-1:0] vec,
    input logic [MAX_W-1:0]    elem,
    input int                  idx,
    input int                  w
  );
    logic [MAX_BITS-1:0] field_mask;
    logic [MAX_BITS-1:0] field;
    field_mask = MAX_BITS'(~({MAX_W{1'b1}} << w));
    field      = (MAX_BITS'(elem) & field_mask) << (idx * w);
    field_mask = field_mask << (idx * w);
    return (vec & ~field_mask) | field;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sorter_oets_cmp_swap.sv
// ============================================================================
// Module : cmp_swap
// Brief  : One unsigned compare-exchange cell; equal values are never swapped.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cmp_swap #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         descend,
  output logic [W-1:0] lo_idx_out,
  output logic [W-1:0] hi_idx_out,
  output logic         swapped
);

  assign swapped    = descend ? (a < b) : (a > b);
  assign lo_idx_out = swapped ? b : a;
  assign hi_idx_out = swapped ? a : b;

endmodule

`default_nettype wire

// File: rtl/sorter_oets.sv
// ============================================================================
// Module : sorter_oets
// Brief  : Iterative odd-even transposition sorter, one layer per clock, with
//          valid/ready handshakes. Define SORTER_OETS_EARLY_EXIT_EN to finish
//          as soon as an even and an odd layer in a row make no swaps.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sorter_oets
  import sorter_pkg::*;
#(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N*W-1:0] sort_in,
  input  logic         descend,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N*W-1:0] sort_out
);

  localparam int NC = N / 2;

  state_t            state, state_nxt;
  logic [W-1:0]      arr    [N];
  logic [W-1:0]      layer  [N];
  logic [W-1:0]      in_arr [N];
  logic [CW-1:0]     phase;
  logic              mode;
  logic              odd;
  logic              load;
  logic              finish;
  logic              early;
  logic [N*W-1:0]    layer_packed;
  logic [MAX_BITS-1:0] packed_layer;

  logic [NC-1:0]     cell_swp;
  logic [NC-1:0]     cell_act;
  logic [W-1:0]      cell_lo [NC];
  logic [W-1:0]      cell_hi [NC];

  assign odd = phase[0];

  // Cell k serves pair (2k,2k+1) on even layers and (2k+1,2k+2) on odd ones.
  generate
    for (genvar k = 0; k < NC; k++) begin : g_cell
      logic [W-1:0] a_sel, b_sel;
      if (2*k + 2 < N) begin : g_full
        assign a_sel       = odd ? arr[2*k+1] : arr[2*k];
        assign b_sel       = odd ? arr[2*k+2] : arr[2*k+1];
        assign cell_act[k] = 1'b1;
      end else begin : g_even_only
        assign a_sel       = arr[2*k];
        assign b_sel       = arr[2*k+1];
        assign cell_act[k] = ~odd;
      end
      cmp_swap #(.W(W)) u_cmp_swap (
        .a          (a_sel),
        .b          (b_sel),
        .descend    (mode),
        .lo_idx_out (cell_lo[k]),
        .hi_idx_out (cell_hi[k]),
        .swapped    (cell_swp[k])
      );
    end

    for (genvar i = 0; i < N; i++) begin : g_elem
      logic [W-1:0] ev, od;
      if (i % 2 == 0) begin : g_ev_lo
        if (i + 1 < N) begin : g_pair
          assign ev = cell_lo[i/2];
        end else begin : g_pass
          assign ev = arr[i];
        end
      end else begin : g_ev_hi
        assign ev = cell_hi[(i-1)/2];
      end
      if (i == 0) begin : g_od_first
        assign od = arr[0];
      end else if (i % 2 == 1) begin : g_od_lo
        if (i + 1 < N) begin : g_pair
          assign od = cell_lo[(i-1)/2];
        end else begin : g_pass
          assign od = arr[i];
        end
      end else begin : g_od_hi
        assign od = cell_hi[(i-2)/2];
      end
      assign layer[i] = odd ? od : ev;
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_arr[i] = W'(unpack_elem(MAX_BITS'(sort_in), i, W));
    end
  end

  always_comb begin
    packed_layer = '0;
    for (int i = 0; i < N; i++) begin
      packed_layer = pack_elem(packed_layer, MAX_W'(layer[i]), i, W);
    end
  end
  assign layer_packed = (N*W)'(packed_layer);

`ifdef SORTER_OETS_EARLY_EXIT_EN
  logic any_swap;
  logic quiet;

  assign any_swap = |(cell_swp & cell_act);

  // quiet: the previous layer of this vector exchanged nothing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quiet <= 1'b0;
    end else if (load) begin
      quiet <= 1'b0;
    end else if (state == SORT) begin
      quiet <= ~any_swap;
    end
  end

  assign early = quiet & ~any_swap;
`else
  logic unused_swp;
  assign unused_swp = ^{cell_swp, cell_act};
  assign early      = 1'b0;
`endif

  assign finish = (state == SORT) & ((phase == CW'(N - 1)) | early);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = SORT;
        end
      end
      SORT: begin
        if (finish) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            load      = 1'b1;
            state_nxt = SORT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      sort_out  <= '0;
      phase     <= '0;
      mode      <= 1'b0;
      for (int i = 0; i < N; i++) arr[i] <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        arr   <= in_arr;
        mode  <= descend;
        phase <= '0;
      end else if (state == SORT) begin
        arr   <= layer;
        phase <= phase + CW'(1);
      end
      if (finish) begin
        sort_out  <= layer_packed;
        out_valid <= 1'b1;
      end else if ((state == DONE) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sorter_oets.sv
// ============================================================================
// Module : tb_sorter_oets
// Brief  : Scoreboard bench for sorter_oets (N=8, W=8) with directed vectors.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sorter_oets;

  localparam int N = 8;
  localparam int W = 8;

`ifdef SORTER_OETS_EARLY_EXIT_EN
  localparam int LAT_SORTED = 2;
  localparam int LAT_ANY    = -1;
`else
  localparam int LAT_SORTED = 8;
  localparam int LAT_ANY    = 8;
`endif

  localparam logic [63:0] V1    = 64'h0280_07FF_0001_0703;
  localparam logic [63:0] V1_D  = 64'h0001_0203_0707_80FF;
  localparam logic [63:0] V1_A  = 64'hFF80_0707_0302_0100;
  localparam logic [63:0] V_AA  = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] V_ALT = 64'hFF00_FF00_FF00_FF00;
  localparam logic [63:0] V_ALT_D = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] V_DSC = 64'h0001_0203_0405_0607;
  localparam logic [63:0] V_ASC = 64'h0706_0504_0302_0100;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] sort_in = '0;
  logic           descend = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [N*W-1:0] sort_out;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [N*W-1:0] data;
    int             acc;
    int             lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   ov_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sorter_oets #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sort_in   (sort_in),
    .descend   (descend),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sort_out  (sort_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Compare each new result against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (out_valid && !ov_prev) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %h, expected no result", sort_out);
      end else begin
        mon_e = sb.pop_front();
        check("result", sort_out, mon_e.data);
        if (mon_e.lat >= 0) check("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
      end
    end
    ov_prev = out_valid;
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [63:0] data, input logic desc, input int lat, input logic [63:0] exp);
    int t;
    in_valid = 1'b1;
    sort_in  = data;
    descend  = desc;
    #1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready got 0, expected 1");
    end
    sb.push_back('{data: exp, acc: cyc + 1, lat: lat});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (sb.size() > 0) begin
      fails++;
      $display("FAIL drain_timeout: pending got %0d, expected 0", sb.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_sort_out", sort_out, 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Descending sort held under backpressure
    out_ready = 1'b0;
    send(V1, 1'b1, LAT_ANY, V1_D);
    t = 0;
    while (!out_valid && t < 30) begin
      @(negedge clk);
      t++;
    end
    check("bp_out_valid_rise", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid_hold", 64'(out_valid), 64'd1);
      check("bp_sort_out_hold", sort_out, V1_D);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
    end

    // Release with a new vector waiting: accepted on the same edge
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sort_in   = V1;
    descend   = 1'b0;
    #1;
    check("b2b_in_ready", 64'(in_ready), 64'd1);
    sb.push_back('{data: V1_A, acc: cyc + 1, lat: LAT_ANY});
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_out_valid_drop", 64'(out_valid), 64'd0);
    drain();

    // Reset during the phase-3 layer aborts the sort
    send(V1, 1'b1, LAT_ANY, V1_D);
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_sort_out", sort_out, 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    send(V1, 1'b1, LAT_ANY, V1_D);
    drain();

    // Duplicates, extremes and presorted/reversed inputs
    send(V_AA, 1'b1, LAT_SORTED, V_AA);
    send(V_AA, 1'b0, LAT_SORTED, V_AA);
    send(V_ALT, 1'b1, LAT_ANY, V_ALT_D);
    send(V_DSC, 1'b1, LAT_SORTED, V_DSC);
    send(V_ASC, 1'b1, 8, V_DSC);
    send(V_DSC, 1'b0, 8, V_ASC);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
